alu_cmd_sequencer: RTL

Hardware initiator for the `ALU` issue port: the hardware counterpart of what the ALU bench does by hand.
- Accepts ALU commands from an upstream master over a valid/ready channel and buffers them in a small FIFO.
- Issues one command at a time to the ALU (`start_alu` pulse with operands held stable), waits for `valid_alu` under a watchdog, and returns tagged results over a valid/ready response channel.
- Sits between the core's execute stage and the multi-cycle ALU.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_fifo.sv | 53 +++++
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the
// command record carried through the command FIFO.
package alu_seq_pkg;

  localparam int SEQ_WIDTH = 32;
  localparam int SEQ_TAG_W = 4;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_XOR   = 5'd2;
  localparam logic [4:0] OP_NOT   = 5'd3;
  localparam logic [4:0] OP_NOR   = 5'd4;
  localparam logic [4:0] OP_NAND  = 5'd5;
  localparam logic [4:0] OP_ADD   = 5'd6;
  localparam logic [4:0] OP_SUB   = 5'd7;
  localparam logic [4:0] OP_FPMUL = 5'd8;
  localparam logic [4:0] OP_EXP   = 5'd9;
  localparam logic [4:0] OP_DIV   = 5'd10;
  localparam logic [4:0] OP_MOD   = 5'd11;
  localparam logic [4:0] OP_MAC   = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  typedef struct packed {
    logic [4:0]           op;
    logic [SEQ_WIDTH-1:0] a;
    logic [SEQ_WIDTH-1:0] b;
    logic                 rs1_signed;
    logic                 rs2_signed;
    logic                 fp;
    logic [SEQ_TAG_W-1:0] tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO with occupancy-based full/empty flags.
// Storage is not reset; only pointers and count are, which flushes the queue.
module alu_seq_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to a multi-cycle ALU under a
// watchdog, and returns tagged results in command order.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = SEQ_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = SEQ_TAG_W,
  parameter int TIMEOUT = 2047
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_rs1_signed,
  input  logic             cmd_rs2_signed,
  input  logic             cmd_fp,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             start_alu,
  output logic [4:0]       op,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             rs1_signed,
  output logic             rs2_signed,
  output logic             operation_ieee754_or_integer,
  input  logic             busy_alu,
  input  logic             valid_alu,
  input  logic             error_alu,
  input  logic [WIDTH-1:0] result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_error,
  output logic             rsp_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_t       state_q, state_d;
  alu_cmd_t         cmd_in, cmd_head;
  logic             fifo_full, fifo_empty;
  logic             pop_head, capture, expire, wd_expired;
  logic [TAG_W-1:0] tag_q;
  logic [WD_W-1:0]  wd_q;

  always_comb begin
    cmd_in            = '0;
    cmd_in.op         = cmd_op;
    cmd_in.a          = SEQ_WIDTH'(cmd_a);
    cmd_in.b          = SEQ_WIDTH'(cmd_b);
    cmd_in.rs1_signed = cmd_rs1_signed;
    cmd_in.rs2_signed = cmd_rs2_signed;
    cmd_in.fp         = cmd_fp;
    cmd_in.tag        = SEQ_TAG_W'(cmd_tag);
  end

  assign cmd_ready = !fifo_full;

  alu_seq_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W ($bits(alu_cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (cmd_valid),
    .wr_data (cmd_in),
    .pop     (pop_head),
    .rd_data (cmd_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // valid_alu is only honoured in WAIT; ISSUE and RESP/IDLE drop it as stale.
  always_comb begin
    state_d  = state_q;
    pop_head = 1'b0;
    capture  = 1'b0;
    expire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy_alu) begin
          pop_head = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (valid_alu) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          expire  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // start_alu is registered so it cannot glitch while reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_alu                    <= 1'b0;
      op                           <= '0;
      A                            <= '0;
      B                            <= '0;
      rs1_signed                   <= 1'b0;
      rs2_signed                   <= 1'b0;
      operation_ieee754_or_integer <= 1'b0;
      tag_q                        <= '0;
      wd_q                         <= '0;
      rsp_valid                    <= 1'b0;
      rsp_result                   <= '0;
      rsp_tag                      <= '0;
      rsp_error                    <= 1'b0;
      rsp_timeout                  <= 1'b0;
    end else begin
      start_alu <= pop_head;
      rsp_valid <= (state_d == ST_RESP);
      if (pop_head) begin
        op                           <= cmd_head.op;
        A                            <= WIDTH'(cmd_head.a);
        B                            <= WIDTH'(cmd_head.b);
        rs1_signed                   <= cmd_head.rs1_signed;
        rs2_signed                   <= cmd_head.rs2_signed;
        operation_ieee754_or_integer <= cmd_head.fp;
        tag_q                        <= TAG_W'(cmd_head.tag);
      end
      if (state_q == ST_ISSUE) begin
        wd_q <= '0;
      end else if ((state_q == ST_WAIT) && !valid_alu && !wd_expired) begin
        wd_q <= wd_q + 1'b1;
      end
      if (capture) begin
        rsp_result  <= result;
        rsp_error   <= error_alu;
        rsp_timeout <= 1'b0;
        rsp_tag     <= tag_q;
      end else if (expire) begin
        rsp_result  <= '0;
        rsp_error   <= 1'b0;
        rsp_timeout <= 1'b1;
        rsp_tag     <= tag_q;
      end
    end
  end

endmodule
